// File: rtl/imem_boot_loader.sv
// Program-load stage: assembles big-endian 32-bit words from a byte stream,
// writes them to instruction memory from address 0 and holds the core in reset until done.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         depth_lim = CW'(DEPTH);
  localparam logic [CW-1:0]         cw_zero   = CW'(1'b0);
  localparam logic [CW-1:0]         cw_one    = CW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] addr_zero = ADDR_WIDTH'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] addr_one  = ADDR_WIDTH'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSEMBLE = 3'd1,
    S_WRITE    = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    load_s;
  logic                    xfer_s;
  logic                    last_s;
  logic [1:0]              byte_idx_r;
  logic [31:0]             word_r;
  logic [CW-1:0]           count_r;
  logic [ADDR_WIDTH-1:0]   addr_r;

  // An abort in the same cycle as a byte transfer drops the byte.
  assign xfer_s = (state_r == S_ASSEMBLE) && in_valid && in_ready && !abort;
  assign last_s = (({1'b0, addr_r} + cw_one) == count_r);

  assign imem_addr  = addr_r;
  assign imem_wdata = word_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a start is honoured from any idle-like state.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (word_count == cw_zero) begin
            state_s = S_DONE;
          end else if (word_count > depth_lim) begin
            state_s = S_ERROR;
          end else begin
            state_s = S_ASSEMBLE;
            load_s  = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_ASSEMBLE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (xfer_s && (byte_idx_r == 2'd3)) begin
          state_s = S_WRITE;
        end else begin
          state_s = S_ASSEMBLE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ASSEMBLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Word assembly, byte index, word counter and write address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_r <= 2'd0;
      word_r     <= 32'd0;
      count_r    <= cw_zero;
      addr_r     <= addr_zero;
    end else if (load_s) begin
      byte_idx_r <= 2'd0;
      word_r     <= 32'd0;
      count_r    <= word_count;
      addr_r     <= addr_zero;
    end else if ((state_r == S_ASSEMBLE) && abort) begin
      byte_idx_r <= 2'd0;
    end else if (xfer_s) begin
      word_r     <= {word_r[23:0], in_data};
      byte_idx_r <= byte_idx_r + 2'd1;
    end else if ((state_r == S_WRITE) && (state_s == S_ASSEMBLE)) begin
      addr_r     <= addr_r + addr_one;
    end else begin
      byte_idx_r <= byte_idx_r;
    end
  end

  // Moore outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b0;
      imem_we  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      in_ready <= (state_s == S_ASSEMBLE);
      imem_we  <= (state_s == S_WRITE);
      busy     <= (state_s == S_ASSEMBLE) || (state_s == S_WRITE);
      done     <= (state_s == S_DONE);
      error    <= (state_s == S_ERROR);
      cpu_rst  <= (state_s != S_DONE);
    end
  end

endmodule
